// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH runtime-programmable square-wave dividers fed
// from one source clock, with glitch-free interval reload, enable and sync.
//
// Ports:
//   clock_in     source clock, all logic on its rising edge
//   reset        asynchronous, active-high reset
//   enable       per-channel run enable; low freezes counter and output
//   sync         one-cycle pulse restarting every channel in phase
//   wr_valid     interval write request
//   wr_ready     write can be accepted (combinational)
//   wr_ch        target channel; out-of-range values are accepted and dropped
//   wr_interval  new half-period in clock_in cycles
//   clock_out    divided clocks, registered
//   tick         one-cycle strobe on each clock_out rising edge
//
// Build option: define DIVIDER_TICK_EN to build the tick registers;
// otherwise tick is tied to zero.

module multi_clock_divider #(
    parameter int NUM_CH           = 4,
    parameter int COUNTER_SIZE     = 24,
    parameter int DEFAULT_INTERVAL = 12000000,
    parameter int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic                    sync,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [COUNTER_SIZE-1:0] wr_interval,
    output logic [NUM_CH-1:0]       clock_out,
    output logic [NUM_CH-1:0]       tick
);

    localparam logic [COUNTER_SIZE-1:0] DEF_IV = COUNTER_SIZE'(DEFAULT_INTERVAL);
    localparam logic [COUNTER_SIZE-1:0] ONE    = COUNTER_SIZE'(1);

    logic [COUNTER_SIZE-1:0] cnt_q  [NUM_CH];
    logic [COUNTER_SIZE-1:0] cnt_d  [NUM_CH];
    logic [COUNTER_SIZE-1:0] act_q  [NUM_CH];
    logic [COUNTER_SIZE-1:0] act_d  [NUM_CH];
    logic [COUNTER_SIZE-1:0] pend_q [NUM_CH];
    logic [COUNTER_SIZE-1:0] pend_d [NUM_CH];

    logic [NUM_CH-1:0] pend_valid_q, pend_valid_d;
    logic [NUM_CH-1:0] clock_out_q, clock_out_d;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] toggle;

    // Out-of-range channels never stall, so their writes simply vanish.
    always_comb begin
        wr_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ch == CH_W'(i)) begin
                wr_ready = ~pend_valid_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_valid && wr_ready && (wr_ch == CH_W'(i));
        end
    end

    // Sync wins over everything; a stopped or disabled channel takes a
    // pending interval immediately; a running channel only takes it on a
    // terminal-count edge so the current half-period is never cut short.
    always_comb begin
        apply  = '0;
        toggle = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]        = cnt_q[i];
            act_d[i]        = act_q[i];
            pend_d[i]       = pend_q[i];
            pend_valid_d[i] = pend_valid_q[i];
            clock_out_d[i]  = clock_out_q[i];

            if (sync) begin
                cnt_d[i]       = '0;
                clock_out_d[i] = 1'b0;
                apply[i]       = pend_valid_q[i];
            end else if (act_q[i] == '0) begin
                cnt_d[i]       = '0;
                clock_out_d[i] = 1'b0;
                apply[i]       = pend_valid_q[i];
            end else if (!enable[i]) begin
                apply[i]       = pend_valid_q[i];
            end else if (cnt_q[i] == act_q[i] - ONE) begin
                cnt_d[i]       = '0;
                toggle[i]      = 1'b1;
                clock_out_d[i] = ~clock_out_q[i];
                apply[i]       = pend_valid_q[i];
            end else begin
                cnt_d[i]       = cnt_q[i] + ONE;
            end

            if (apply[i]) begin
                act_d[i]        = pend_q[i];
                cnt_d[i]        = '0;
                pend_valid_d[i] = 1'b0;
            end

            // Acceptance needs pend_valid low, so it never races an apply.
            if (wr_hit[i]) begin
                pend_d[i]       = wr_interval;
                pend_valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= DEF_IV;
                pend_q[i] <= '0;
            end
            pend_valid_q <= '0;
            clock_out_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                act_q[i]  <= act_d[i];
                pend_q[i] <= pend_d[i];
            end
            pend_valid_q <= pend_valid_d;
            clock_out_q  <= clock_out_d;
        end
    end

    assign clock_out = clock_out_q;

`ifdef DIVIDER_TICK_EN
    logic [NUM_CH-1:0] tick_q, tick_d;

    // A toggle from low is exactly a rising edge of clock_out.
    always_comb begin
        tick_d = toggle & ~clock_out_q;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    assign tick = '0;
`endif

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: self-checking bench for multi_clock_divider with
// a countdown reference model, scoreboard queue and a vector table.

module tb_multi_clock_divider;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 3;

`ifdef DIVIDER_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic           clock_in = 1'b0;
    logic           reset;
    logic [NCH-1:0] enable;
    logic           sync;
    logic           wr_valid;
    logic           wr_ready;
    logic [1:0]     wr_ch;
    logic [CW-1:0]  wr_interval;
    logic [NCH-1:0] clock_out;
    logic [NCH-1:0] tick;

    multi_clock_divider #(
        .NUM_CH(NCH),
        .COUNTER_SIZE(CW),
        .DEFAULT_INTERVAL(DEF)
    ) dut (
        .clock_in(clock_in),
        .reset(reset),
        .enable(enable),
        .sync(sync),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_ch(wr_ch),
        .wr_interval(wr_interval),
        .clock_out(clock_out),
        .tick(tick)
    );

    always #5 clock_in = ~clock_in;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: counts down edges remaining until the next toggle.
    int             m_rem  [NCH];
    logic [CW-1:0]  m_act  [NCH];
    logic [CW-1:0]  m_pend [NCH];
    logic [NCH-1:0] m_pv;
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;

    typedef struct {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tk;
    } exp_t;

    exp_t sb[$];

    function automatic logic model_ready(logic [1:0] ch);
        if (int'(ch) >= NCH) return 1'b1;
        return ~m_pv[ch];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_rem[i]  = DEF;
            m_act[i]  = CW'(DEF);
            m_pend[i] = '0;
        end
        m_pv   = '0;
        m_clk  = '0;
        m_tick = '0;
    endtask

    task automatic model_take(int i);
        if (m_pv[i]) begin
            m_act[i] = m_pend[i];
            m_pv[i]  = 1'b0;
            m_rem[i] = int'(m_act[i]);
        end
    endtask

    task automatic model_edge();
        logic [NCH-1:0] acc;
        for (int i = 0; i < NCH; i++)
            acc[i] = wr_valid && (int'(wr_ch) == i) && !m_pv[i];
        for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 1'b0;
            if (sync || m_act[i] == '0) begin
                model_take(i);
                m_clk[i] = 1'b0;
                m_rem[i] = int'(m_act[i]);
            end else if (!enable[i]) begin
                model_take(i);
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_clk[i]  = ~m_clk[i];
                    m_tick[i] = m_clk[i];
                    model_take(i);
                    m_rem[i]  = int'(m_act[i]);
                end
            end
            if (acc[i]) begin
                m_pend[i] = wr_interval;
                m_pv[i]   = 1'b1;
            end
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        exp_t e;
        #1;
        check("wr_ready", wr_ready, model_ready(wr_ch));
        model_edge();
        e.clk = m_clk;
        e.tk  = TICK_EN ? m_tick : '0;
        sb.push_back(e);
        @(posedge clock_in);
        #1;
        e = sb.pop_front();
        check("clock_out", clock_out, e.clk);
        check("tick", tick, e.tk);
        @(negedge clock_in);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_clock_out", clock_out, 0);
        check("rst_tick", tick, 0);
        check("rst_wr_ready", wr_ready, 1);
        @(negedge clock_in);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic           sy;
        logic           wv;
        logic [1:0]     ch;
        logic [CW-1:0]  iv;
        int             reps;
        logic           rdy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b111, 1'b0, 1'b1, 2'd0, 8'd1, 1,  1'b1};
        tbl[1]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1,  1'b0};
        tbl[2]  = '{3'b111, 1'b0, 1'b1, 2'd1, 8'd2, 1,  1'b1};
        tbl[3]  = '{3'b111, 1'b0, 1'b1, 2'd1, 8'd5, 1,  1'b0};
        tbl[4]  = '{3'b101, 1'b0, 1'b0, 2'd1, 8'd0, 1,  1'b0};
        tbl[5]  = '{3'b111, 1'b0, 1'b1, 2'd1, 8'd5, 1,  1'b1};
        tbl[6]  = '{3'b111, 1'b1, 1'b1, 2'd2, 8'd6, 1,  1'b1};
        tbl[7]  = '{3'b111, 1'b0, 1'b0, 2'd2, 8'd0, 10, 1'b0};
        tbl[8]  = '{3'b110, 1'b0, 1'b1, 2'd0, 8'd0, 3,  1'b1};
        tbl[9]  = '{3'b111, 1'b0, 1'b1, 2'd3, 8'd9, 2,  1'b1};
        tbl[10] = '{3'b111, 1'b0, 1'b1, 2'd0, 8'd2, 1,  1'b1};
        tbl[11] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 12, 1'b0};

        enable      = '1;
        sync        = 1'b0;
        wr_valid    = 1'b0;
        wr_ch       = 2'd0;
        wr_interval = '0;

        // Default interval: rises at 3, 9, 15 and falls at 6, 12.
        apply_reset();
        for (int e = 1; e <= 15; e++) begin
            step();
            check("t1_clk", clock_out, ((e / 3) % 2 == 1) ? 3'b111 : 3'b000);
            check("t1_tick", tick, (TICK_EN && (e % 6 == 3)) ? 3'b111 : 3'b000);
        end

        // Channel 1 to N=5 via sync, then reload to 2 at cnt=1.
        wr_ch = 2'd1; wr_interval = 8'd5; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0; sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        wr_interval = 8'd2; wr_valid = 1'b1;
        #1 check("t2_ready_accept", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1 check("t2_ready_stall", wr_ready, 0);
            step();
        end
        #1 check("t2_ready_back", wr_ready, 1);
        check("t2_apply_clk", clock_out[1], 1);
        for (int j = 1; j <= 5; j++) begin
            step();
            check("t2_half2", clock_out[1], ((j / 2) % 2 == 0) ? 1 : 0);
        end

        // Channel 2 stopped with N=0, then restarted with N=4.
        wr_ch = 2'd2; wr_interval = 8'd0; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        repeat (6) step();
        for (int j = 0; j < 4; j++) begin
            check("t3_stopped", clock_out[2], 0);
            step();
        end
        wr_interval = 8'd4; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        for (int j = 1; j <= 4; j++) begin
            step();
            check("t3_restart", clock_out[2], (j == 4) ? 1 : 0);
        end

        // N=3 and N=4, freeze channel 0, then sync.
        wr_ch = 2'd1; wr_interval = 8'd4; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0; sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (4) step();
        enable = 3'b110;
        for (int j = 0; j < 5; j++) begin
            step();
            check("t4_frozen", clock_out[0], 1);
        end
        enable = 3'b111;
        step();
        check("t4_resume1", clock_out[0], 1);
        step();
        check("t4_resume2", clock_out[0], 0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t4_sync", clock_out[1:0], 0);
        for (int j = 1; j <= 4; j++) begin
            step();
            check("t4_ch0", clock_out[0], (j >= 3) ? 1 : 0);
            check("t4_ch1", clock_out[1], (j == 4) ? 1 : 0);
        end

        // Out-of-range write, then reset with a pending interval.
        wr_ch = 2'd3; wr_interval = 8'd9; wr_valid = 1'b1;
        #1 check("t5_oor_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        repeat (3) step();
        wr_ch = 2'd0; wr_interval = 8'd7; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        #1 check("t5_pending", wr_ready, 0);
        #2 apply_reset();
        for (int e = 1; e <= 6; e++) begin
            step();
            check("t5_default", clock_out[0], ((e / 3) % 2 == 1) ? 1 : 0);
        end

        // Mixed vector table from a fresh reset.
        apply_reset();
        for (int r = 0; r < 12; r++) begin
            enable      = tbl[r].en;
            sync        = tbl[r].sy;
            wr_valid    = tbl[r].wv;
            wr_ch       = tbl[r].ch;
            wr_interval = tbl[r].iv;
            #1 check("tbl_ready", wr_ready, tbl[r].rdy);
            repeat (tbl[r].reps) step();
        end
        sync     = 1'b0;
        wr_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
